seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of hex digits scanned, legal range 2..16.
REQ-002 The block SHALL have parameter PRESCALE, default 4: clock cycles each digit is displayed, legal range >=1.
REQ-003 The block SHALL have a clk port (input, 1 bit): the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have a reset port (input, 1 bit): reset is synchronous and active-high.
REQ-005 The block SHALL have a load port (input, 1 bit): request to capture data_in this cycle.
REQ-006 The block SHALL have a data_in port (input, 4*DIGITS bits): digit k is data_in[4k+3:4k], and digit 0 is least significant.
REQ-007 The block SHALL have a blank_lz port (input, 1 bit): when 1, leading-zero suppression is enabled.
REQ-008 The block SHALL have an an port (output, DIGITS bits): registered, one-hot, active-high digit enable.
REQ-009 The block SHALL have a seg port (output, 7 bits): registered, active-high segments, with seg[0]=a through seg[6]=g.
REQ-010 The block SHALL have a pending port (output, 1 bit): 1 while accepted data waits for the frame boundary.
REQ-011 The block SHALL have a frame_done port (output, 1 bit): registered, one-cycle pulse after each frame wrap.

Function
REQ-012 The block SHALL hold state in a prescale counter pre (0..PRESCALE-1), a digit index idx (0..DIGITS-1), a pend_data register, a pend flag, and a shadow display register.
REQ-013 pre SHALL increment every cycle and wrap from PRESCALE-1 to 0; with PRESCALE=1, pre is constant 0 and idx advances every cycle.
REQ-014 idx SHALL increment only on a cycle where pre==PRESCALE-1, wrapping from DIGITS-1 to 0 with no skipped or repeated digit.
REQ-015 A frame boundary SHALL be the cycle where pre==PRESCALE-1 and idx==DIGITS-1, giving a frame length of DIGITS*PRESCALE cycles.
REQ-016 At a frame boundary with pend=1 and load=0, shadow SHALL take pend_data and pend SHALL clear.
REQ-017 When load=1 on a non-boundary cycle, pend_data SHALL take data_in and pend SHALL set; a later load before the boundary overwrites pend_data (last write wins).
REQ-018 When load=1 on a boundary cycle, shadow SHALL take data_in directly, any older pend_data SHALL be discarded, and pend SHALL clear.
REQ-019 shadow SHALL never change except at a frame boundary, so no frame ever shows mixed old and new data.
REQ-020 Each cycle, an SHALL register the one-hot encoding of the next idx, and seg SHALL register decode(shadow digit next idx), using next-state shadow.
REQ-021 decode SHALL map values 0..F to 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (hex) respectively.
REQ-022 With blank_lz=1, a digit k>=1 SHALL show seg=00 if it and every digit above it in shadow are 0; digit 0 always shows its decoded value, and an is unaffected.
REQ-023 blank_lz SHALL be sampled combinationally into the seg register each cycle, and a change SHALL take effect on the next digit update.
REQ-024 frame_done SHALL be 1 on exactly the cycle after each frame-boundary edge and 0 otherwise.
REQ-025 pending SHALL equal the pend flag directly.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL set pre=0, idx=0, shadow=0, pend_data=0, pend=0, an=0, seg=00, and frame_done=0; load is ignored.
REQ-027 On the first edge with reset=0, the block SHALL set an=...0001 and seg=3F for digit 0 of shadow 0.
REQ-028 Reset asserted mid-frame or with pend=1 SHALL discard pending data, with no frame_done pulse and no shadow update.

Verification (DIGITS=4, PRESCALE=4)
REQ-029 Scan check: reset, then free-run 32 cycles -> an cycles 0001,0010,0100,1000 every 4 cycles; frame_done pulses every 16 cycles; seg=3F throughout.
REQ-030 Deferred load: load=1 with data_in=16'h12AF at mid-frame -> pending=1 until the boundary; the next frame shows digit0=71, digit1=77, digit2=5B, digit3=06; pending then 0.
REQ-031 Boundary load: load on the exact boundary cycle with 16'h0005, while pend holds 16'h9999 -> the next frame shows 0005, the 9999 value is never displayed, and pending=0.
REQ-032 Last write wins: loads of 16'h1111 then 16'h2222 within one frame -> the next frame shows 2222 only.
REQ-033 Leading-zero suppression: shadow=16'h0040 with blank_lz=1 -> digit3=00, digit2=00, digit1=66, digit0=3F; shadow=0 -> digits 3..1=00, digit0=3F.
REQ-034 Reset mid-frame with pend=1 -> the next frame shows 0000 (all 3F), pending=0, and the first frame_done comes 16 cycles after reset release.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed hex seven-segment scan driver: cycles through DIGITS digits,
// PRESCALE clocks each, with frame-synchronous double-buffered data updates
// and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned DW = 4 * DIGITS;

  // Hex digit to active-high segment pattern (bit 0 = a ... bit 6 = g).
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic [DW-1:0]     pend_data_q, pend_data_d;
  logic              pend_q, pend_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;

  logic              pre_wrap;
  logic              boundary;
  logic [DIGITS-1:0] lz_mask;
  logic              lz_acc;
  logic [3:0]        dig_sel;
  logic              blank_sel;

  // Scan counters and frame boundary detection.
  always_comb begin
    pre_wrap = (pre_q == PW'(PRESCALE - 1));
    boundary = pre_wrap && (idx_q == IW'(DIGITS - 1));
    pre_d    = pre_wrap ? '0 : pre_q + PW'(1);
    idx_d    = idx_q;
    if (pre_wrap) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Double-buffer: loads park in pend_data, shadow only moves at the boundary.
  always_comb begin
    shadow_d    = shadow_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    if (load && boundary) begin
      shadow_d = data_in;
      pend_d   = 1'b0;
    end else if (load) begin
      pend_data_d = data_in;
      pend_d      = 1'b1;
    end else if (boundary && pend_q) begin
      shadow_d = pend_data_q;
      pend_d   = 1'b0;
    end
  end

  // Leading-zero mask: bit k set when digit k and all digits above are zero.
  always_comb begin
    lz_mask = '0;
    lz_acc  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_acc     = lz_acc & (shadow_d[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_acc;
    end
  end

  // Digit enable and segment pattern for the upcoming digit.
  always_comb begin
    an_d      = '0;
    dig_sel   = 4'h0;
    blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        an_d[k]   = 1'b1;
        dig_sel   = shadow_d[4*k +: 4];
        blank_sel = (k != 0) && lz_mask[k];
      end
    end
    seg_d        = (blank_lz && blank_sel) ? 7'h00 : decode(dig_sel);
    frame_done_d = boundary;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pend_data_q  <= '0;
      pend_q       <= 1'b0;
      an_q         <= '0;
      seg_q        <= 7'h00;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_data_q  <= pend_data_d;
      pend_q       <= pend_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pending    = pend_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, PRESCALE=4): stimulus pushes
// the expected post-edge outputs, a monitor pops and compares after each edge.
module tb_seg_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] data_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          k     = 0;
  logic        blz_v = 1'b0;
  logic [6:0]  tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reset cycles: every output expected zero.
  task automatic rst_cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset   = 1'b1;
      load    = 1'b1;
      data_in = 16'hFFFF;
      e = '{an: 4'h0, seg: 7'h00, fd: 1'b0, pend: 1'b0};
      exp_q.push_back(e);
    end
    k = 0;
  endtask

  // One running cycle; sh/p are the shadow contents and pending flag after the edge.
  task automatic cyc(input logic ld, input logic [15:0] d, input logic [15:0] sh, input logic p);
    exp_t       e;
    int         kn;
    int         ix;
    logic [15:0] upper;
    @(negedge clk);
    reset    = 1'b0;
    load     = ld;
    data_in  = d;
    blank_lz = blz_v;
    kn    = k + 1;
    ix    = (kn / 4) % 4;
    upper = sh >> (4 * ix);
    e.an   = 4'(1 << ix);
    e.fd   = (kn % 16) == 0;
    e.pend = p;
    e.seg  = (blz_v && ix >= 1 && upper == 16'h0) ? 7'h00 : tbl[upper[3:0]];
    exp_q.push_back(e);
    k = kn;
  endtask

  task automatic run_to(input int kend, input logic [15:0] sh, input logic p);
    while (k < kend) cyc(1'b0, 16'h0000, sh, p);
  endtask

  // Monitor: compare the DUT outputs after each edge against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (an !== e.an || seg !== e.seg || frame_done !== e.fd || pending !== e.pend) begin
          n_bad++;
          $display("FAIL vec%0d: got an=%b seg=%h fd=%b pend=%b, expected an=%b seg=%h fd=%b pend=%b",
                   n_vec, an, seg, frame_done, pending, e.an, e.seg, e.fd, e.pend);
        end
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1; load = 1'b0; data_in = 16'h0; blank_lz = 1'b0;
    rst_cyc(2);
    // free-running scan on all-zero shadow
    run_to(32, 16'h0000, 1'b0);
    // deferred load mid-frame
    run_to(37, 16'h0000, 1'b0);
    cyc(1'b1, 16'h12AF, 16'h0000, 1'b1);
    run_to(47, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 16'h12AF, 1'b0);
    run_to(64, 16'h12AF, 1'b0);
    // boundary load overrides a pending 9999
    run_to(70, 16'h12AF, 1'b0);
    cyc(1'b1, 16'h9999, 16'h12AF, 1'b1);
    run_to(79, 16'h12AF, 1'b1);
    cyc(1'b1, 16'h0005, 16'h0005, 1'b0);
    run_to(99, 16'h0005, 1'b0);
    // last write wins
    cyc(1'b1, 16'h1111, 16'h0005, 1'b1);
    run_to(104, 16'h0005, 1'b1);
    cyc(1'b1, 16'h2222, 16'h0005, 1'b1);
    run_to(111, 16'h0005, 1'b1);
    cyc(1'b0, 16'h0000, 16'h2222, 1'b0);
    run_to(128, 16'h2222, 1'b0);
    // leading-zero suppression
    blz_v = 1'b1;
    run_to(129, 16'h2222, 1'b0);
    cyc(1'b1, 16'h0040, 16'h2222, 1'b1);
    run_to(143, 16'h2222, 1'b1);
    cyc(1'b0, 16'h0000, 16'h0040, 1'b0);
    run_to(149, 16'h0040, 1'b0);
    cyc(1'b1, 16'h0000, 16'h0040, 1'b1);
    run_to(159, 16'h0040, 1'b1);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
    run_to(176, 16'h0000, 1'b0);
    blz_v = 1'b0;
    // reset mid-frame with data pending
    run_to(179, 16'h0000, 1'b0);
    cyc(1'b1, 16'hABCD, 16'h0000, 1'b1);
    run_to(185, 16'h0000, 1'b1);
    rst_cyc(2);
    run_to(32, 16'h0000, 1'b0);
    @(negedge clk);
    load = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
